// File: rtl/sparc_ifu_thrsched_pkg.sv
// ---------------------------------------------------------------------------
// sparc_ifu_thrsched_pkg
//   Shared definitions for the IFU thread scheduler:
//   - THRFSM_* state codes exactly as driven by the per-thread sparc_ifu_thrfsm
//   - decoded per-thread view (ready / speculatively ready / running)
//   - helper sizing the run-quantum counter
// ---------------------------------------------------------------------------
package sparc_ifu_thrsched_pkg;

   // Thread FSM state codes (mirror of the THRFSM_* defines in ifu.h).
   localparam logic [4:0] THRFSM_IDLE     = 5'b00000;
   localparam logic [4:0] THRFSM_HALT     = 5'b00010;
   localparam logic [4:0] THRFSM_WAIT     = 5'b00001;
   localparam logic [4:0] THRFSM_RDY      = 5'b11001;
   localparam logic [4:0] THRFSM_SPEC_RDY = 5'b10011;
   localparam logic [4:0] THRFSM_RUN      = 5'b00101;
   localparam logic [4:0] THRFSM_SPEC_RUN = 5'b00111;

   typedef struct packed {
      logic rdy;   // ready, non-speculative
      logic srdy;  // ready, speculative
      logic run;   // owns the pipe (RUN or SPEC_RUN)
   } thr_dec_t;

   // Any code outside the known set decodes as neither ready nor running.
   function automatic thr_dec_t decode_state(input logic [4:0] s);
      thr_dec_t d;
      d.rdy  = (s == THRFSM_RDY);
      d.srdy = (s == THRFSM_SPEC_RDY);
      d.run  = (s == THRFSM_RUN) || (s == THRFSM_SPEC_RUN);
      return d;
   endfunction

   // Counter must hold QUANTUM-1; never narrower than one bit.
   function automatic int cnt_width(input int quantum);
      return (quantum <= 2) ? 1 : $clog2(quantum);
   endfunction

endpackage

// File: rtl/sparc_ifu_rrarb.sv
// ---------------------------------------------------------------------------
// sparc_ifu_rrarb
//   N-wide round-robin priority picker. Searches req_i circularly starting
//   at ptr_i+1 and ending at ptr_i, so the previous winner has lowest priority.
// Ports
//   req_i  [N-1:0]   request vector
//   ptr_i  [IW-1:0]  last granted index (must be < N)
//   gnt_o  [N-1:0]   one-hot grant, zero when no request
//   id_o   [IW-1:0]  encoded grant index, zero when no request
// ---------------------------------------------------------------------------
module sparc_ifu_rrarb #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] id_o
);

   logic [IW-1:0] idx;
   logic          found;

   always_comb begin
      // NOTE: every variable written here gets a default before any branch;
      // otherwise a path that skips the assignment would infer a latch.
      gnt_o = '0;
      id_o  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= N; k++) begin
         idx = IW'((int'(ptr_i) + k) % N);
         if (!found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            id_o       = idx;
         end
      end
   end

endmodule

// File: rtl/sparc_ifu_thrsched.sv
// ---------------------------------------------------------------------------
// sparc_ifu_thrsched
//   Thread scheduler for the per-thread sparc_ifu_thrfsm instances. Picks one
//   ready thread round-robin (non-speculative before speculative), drives the
//   one-hot schedule and the common switch_out, and keeps a running thread on
//   the pipe for at least QUANTUM cycles while others wait.
// Ports
//   clk         in   core clock
//   arst_l      in   asynchronous active-low reset
//   thr_state   in   5*NTHR thread states, thread i at [5i+4:5i]
//   fcl_hold    in   pipeline hold; no scheduling decision this cycle
//   schedule    out  one-hot: switch thread i in
//   switch_out  out  switch the running thread out
//   sched_tid   out  id of the last thread scheduled (registered)
//   sched_vld   out  some thread is RUN or SPEC_RUN
//   sched_err   out  sticky: more than one thread running at once
// ---------------------------------------------------------------------------
module sparc_ifu_thrsched
   import sparc_ifu_thrsched_pkg::*;
#(
   parameter  int NTHR    = 4,
   parameter  int QUANTUM = 1,
   localparam int TW      = (NTHR > 1) ? $clog2(NTHR) : 1
) (
   input  logic              clk,
   input  logic              arst_l,
   input  logic [5*NTHR-1:0] thr_state,
   input  logic              fcl_hold,
   output logic [NTHR-1:0]   schedule,
   output logic              switch_out,
   output logic [TW-1:0]     sched_tid,
   output logic              sched_vld,
   output logic              sched_err
);

   localparam int            CW   = cnt_width(QUANTUM);
   localparam logic [CW-1:0] QMAX = CW'(QUANTUM - 1);

   logic [NTHR-1:0] rdy, srdy, run, cand, grant;
   logic [TW-1:0]   pick;
   logic            go, qhit, multi_run;

   logic [TW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [TW-1:0]   sched_tid_q, sched_tid_d;
   logic [CW-1:0]   qcnt_q, qcnt_d;
   logic            sched_err_q, sched_err_d;

   for (genvar i = 0; i < NTHR; i++) begin : g_dec
      thr_dec_t dec;
      assign dec     = decode_state(thr_state[5*i +: 5]);
      assign rdy[i]  = dec.rdy;
      assign srdy[i] = dec.srdy;
      assign run[i]  = dec.run;
   end

   assign sched_vld = |run;
   // Speculative threads are only considered when no thread is plainly ready.
   assign cand      = (|rdy) ? rdy : srdy;
   assign qhit      = (qcnt_q >= QMAX);
   // arst_l in the product forces schedule/switch_out low while in reset.
   assign go        = arst_l & ~fcl_hold & (|cand) & (~sched_vld | qhit);
   // Clearing the lowest set bit leaves something only if two or more were set.
   assign multi_run = |(run & (run - NTHR'(1)));

   sparc_ifu_rrarb #(.N(NTHR), .IW(TW)) u_rrarb (
      .req_i (cand),
      .ptr_i (rr_ptr_q),
      .gnt_o (grant),
      .id_o  (pick)
   );

   assign schedule   = go ? grant : '0;
   assign switch_out = go & sched_vld;
   assign sched_tid  = sched_tid_q;
   assign sched_err  = sched_err_q;

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      sched_tid_d = sched_tid_q;
      qcnt_d      = qcnt_q;
      sched_err_d = sched_err_q | multi_run;
      if (go) begin
         rr_ptr_d    = pick;
         sched_tid_d = pick;
         qcnt_d      = '0;
      end else if (sched_vld) begin
         if (!qhit) qcnt_d = qcnt_q + CW'(1);
      end else begin
         qcnt_d = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; all of them are reset, rr_ptr to NTHR-1 so that
   // thread 0 is the first winner.
   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
         rr_ptr_q    <= TW'(NTHR - 1);
         sched_tid_q <= '0;
         qcnt_q      <= '0;
         sched_err_q <= 1'b0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         sched_tid_q <= sched_tid_d;
         qcnt_q      <= qcnt_d;
         sched_err_q <= sched_err_d;
      end
   end

endmodule

// File: tb/tb_sparc_ifu_thrsched.sv
// ---------------------------------------------------------------------------
// tb_sparc_ifu_thrsched
//   Three scheduler instances (QUANTUM 1, 4, 8), each with its own thread
//   states. The bench plays the thread FSMs: when it predicts a schedule it
//   moves the old runner back to ready and the new thread to running. A
//   behavioural model computes every expected output from the scheduling
//   rules; directed scenarios are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_sparc_ifu_thrsched;

   localparam logic [4:0] S_IDLE  = 5'b00000;
   localparam logic [4:0] S_HALT  = 5'b00010;
   localparam logic [4:0] S_WAIT  = 5'b00001;
   localparam logic [4:0] S_RDY   = 5'b11001;
   localparam logic [4:0] S_SRDY  = 5'b10011;
   localparam logic [4:0] S_RUN   = 5'b00101;
   localparam logic [4:0] S_SRUN  = 5'b00111;

   function automatic int qv_of(input int d);
      return (d == 0) ? 1 : (d == 1) ? 4 : 8;
   endfunction

   logic        clk;
   logic        arst_l;
   logic        fcl_hold;
   logic [19:0] ts_w    [3];
   logic [3:0]  sched_w [3];
   logic        sw_w    [3];
   logic [1:0]  tid_w   [3];
   logic        vld_w   [3];
   logic        err_w   [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sparc_ifu_thrsched #(.NTHR(4), .QUANTUM((g == 0) ? 1 : (g == 1) ? 4 : 8)) u_dut (
         .clk        (clk),
         .arst_l     (arst_l),
         .thr_state  (ts_w[g]),
         .fcl_hold   (fcl_hold),
         .schedule   (sched_w[g]),
         .switch_out (sw_w[g]),
         .sched_tid  (tid_w[g]),
         .sched_vld  (vld_w[g]),
         .sched_err  (err_w[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Bench-side thread states and model state.
   logic [4:0] st [3][4];
   int         m_ptr [3];
   int         m_q   [3];
   int         m_tid [3];
   bit         m_err [3];

   task automatic drive();
      for (int d = 0; d < 3; d++)
         for (int t = 0; t < 4; t++)
            ts_w[d][5*t +: 5] = st[d][t];
   endtask

   task automatic set_thr(input int d, input logic [4:0] s0, input logic [4:0] s1,
                          input logic [4:0] s2, input logic [4:0] s3);
      st[d][0] = s0; st[d][1] = s1; st[d][2] = s2; st[d][3] = s3;
   endtask

   task automatic model_eval(input int d, output logic [3:0] es, output logic esw,
                             output logic evld, output int epick, output bit ego,
                             output bit emulti);
      bit [3:0] r, sr, ru, cand;
      bit       found;
      r = '0; sr = '0; ru = '0;
      for (int t = 0; t < 4; t++) begin
         if (st[d][t] == S_RDY)                             r[t]  = 1'b1;
         else if (st[d][t] == S_SRDY)                       sr[t] = 1'b1;
         else if (st[d][t] == S_RUN || st[d][t] == S_SRUN)  ru[t] = 1'b1;
      end
      evld   = (ru != 0);
      emulti = ($countones(ru) > 1);
      cand   = (r != 0) ? r : sr;
      epick  = 0;
      found  = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         int t;
         t = (m_ptr[d] + k) % 4;
         if (!found && cand[t]) begin
            found = 1'b1;
            epick = t;
         end
      end
      ego = !fcl_hold && (cand != 0) && (!evld || m_q[d] >= qv_of(d) - 1);
      es  = ego ? (4'b0001 << epick) : 4'b0000;
      esw = ego && evld;
   endtask

   // One clock: compare all outputs against the model, advance the model on
   // the edge, then apply the thread-FSM handshake the model predicted.
   task automatic step();
      logic [3:0] es   [3];
      logic       esw, evld;
      int         pk   [3];
      bit         go   [3];
      bit         mul  [3];
      bit         vl   [3];
      #1;
      for (int d = 0; d < 3; d++) begin
         model_eval(d, es[d], esw, evld, pk[d], go[d], mul[d]);
         vl[d] = evld;
         check($sformatf("d%0d schedule", d), 32'(sched_w[d]), 32'(es[d]));
         check($sformatf("d%0d switch_out", d), 32'(sw_w[d]), 32'(esw));
         check($sformatf("d%0d sched_vld", d), 32'(vld_w[d]), 32'(evld));
         check($sformatf("d%0d sched_tid", d), 32'(tid_w[d]), 32'(m_tid[d]));
         check($sformatf("d%0d sched_err", d), 32'(err_w[d]), 32'(m_err[d]));
      end
      @(posedge clk);
      for (int d = 0; d < 3; d++) begin
         if (go[d]) begin
            m_ptr[d] = pk[d];
            m_tid[d] = pk[d];
            m_q[d]   = 0;
         end else if (vl[d]) begin
            if (m_q[d] < qv_of(d) - 1) m_q[d]++;
         end else begin
            m_q[d] = 0;
         end
         m_err[d] = m_err[d] | mul[d];
      end
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         if (go[d]) begin
            for (int t = 0; t < 4; t++) begin
               if (st[d][t] == S_RUN)       st[d][t] = S_RDY;
               else if (st[d][t] == S_SRUN) st[d][t] = S_SRDY;
            end
            if (st[d][pk[d]] == S_RDY)       st[d][pk[d]] = S_RUN;
            else if (st[d][pk[d]] == S_SRDY) st[d][pk[d]] = S_SRUN;
         end
      end
      drive();
   endtask

   // Asserts reset with the current inputs still applied, then with every
   // thread ready, checks outputs are forced low, and releases on a negedge.
   task automatic do_reset();
      arst_l = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst d%0d schedule", d), 32'(sched_w[d]), 32'd0);
         check($sformatf("rst d%0d switch_out", d), 32'(sw_w[d]), 32'd0);
         check($sformatf("rst d%0d sched_tid", d), 32'(tid_w[d]), 32'd0);
         check($sformatf("rst d%0d sched_err", d), 32'(err_w[d]), 32'd0);
      end
      fcl_hold = 1'b0;
      for (int d = 0; d < 3; d++) set_thr(d, S_RDY, S_RDY, S_RDY, S_RDY);
      drive();
      #1;
      for (int d = 0; d < 3; d++)
         check($sformatf("rst rdy d%0d schedule", d), 32'(sched_w[d]), 32'd0);
      @(posedge clk);
      @(negedge clk);
      arst_l = 1'b1;
      for (int d = 0; d < 3; d++) begin
         m_ptr[d] = 3; m_q[d] = 0; m_tid[d] = 0; m_err[d] = 1'b0;
         set_thr(d, S_IDLE, S_IDLE, S_IDLE, S_IDLE);
      end
      drive();
   endtask

   function automatic logic [4:0] rand_code();
      int r;
      r = $urandom_range(0, 99);
      if (r < 30) return S_RDY;
      if (r < 45) return S_SRDY;
      if (r < 55) return S_WAIT;
      if (r < 65) return S_IDLE;
      if (r < 70) return S_HALT;
      if (r < 73) return S_RUN;
      if (r < 75) return S_SRUN;
      return 5'($urandom);
   endfunction

   logic [3:0] seq1 [5];

   initial begin
      arst_l   = 1'b0;
      fcl_hold = 1'b0;
      for (int d = 0; d < 3; d++) set_thr(d, S_IDLE, S_IDLE, S_IDLE, S_IDLE);
      drive();
      @(negedge clk);
      do_reset();

      // Rotation through four ready threads, QUANTUM=1.
      seq1[0] = 4'b0001; seq1[1] = 4'b0010; seq1[2] = 4'b0100;
      seq1[3] = 4'b1000; seq1[4] = 4'b0001;
      set_thr(0, S_RDY, S_RDY, S_RDY, S_RDY);
      drive();
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("rot sched c%0d", k), 32'(sched_w[0]), 32'(seq1[k]));
         check($sformatf("rot sw c%0d", k), 32'(sw_w[0]), (k == 0) ? 32'd0 : 32'd1);
         step();
      end

      // QUANTUM=4: runner keeps the pipe three cycles, then is preempted.
      do_reset();
      set_thr(1, S_RUN, S_RDY, S_IDLE, S_IDLE);
      drive();
      for (int k = 0; k < 3; k++) begin
         #1;
         check($sformatf("quantum wait c%0d", k), 32'(sched_w[1]), 32'd0);
         step();
      end
      #1;
      check("quantum preempt sched", 32'(sched_w[1]), 32'b0010);
      check("quantum preempt sw", 32'(sw_w[1]), 32'd1);
      step();
      #1;
      check("quantum restart", 32'(sched_w[1]), 32'd0);
      step();

      // RDY beats SPEC_RDY; SPEC_RDY taken when alone.
      do_reset();
      set_thr(0, S_RUN, S_IDLE, S_SRDY, S_RDY);
      drive();
      #1;
      check("spec rdy wins", 32'(sched_w[0]), 32'b1000);
      check("spec rdy wins sw", 32'(sw_w[0]), 32'd1);
      step();
      set_thr(0, S_IDLE, S_IDLE, S_SRDY, S_RUN);
      drive();
      #1;
      check("spec only", 32'(sched_w[0]), 32'b0100);
      step();

      // QUANTUM=8: runner stalls, ready thread goes in at once.
      do_reset();
      set_thr(2, S_RDY, S_RUN, S_IDLE, S_IDLE);
      drive();
      #1;
      check("stall before", 32'(sched_w[2]), 32'd0);
      step();
      set_thr(2, S_RDY, S_WAIT, S_IDLE, S_IDLE);
      drive();
      #1;
      check("stall sched", 32'(sched_w[2]), 32'b0001);
      check("stall sw", 32'(sw_w[2]), 32'd0);
      step();

      // Hold freezes the rotation.
      do_reset();
      set_thr(0, S_RDY, S_RDY, S_IDLE, S_IDLE);
      fcl_hold = 1'b1;
      drive();
      for (int k = 0; k < 2; k++) begin
         #1;
         check($sformatf("hold c%0d", k), 32'(sched_w[0]), 32'd0);
         step();
      end
      fcl_hold = 1'b0;
      #1;
      check("hold release 0", 32'(sched_w[0]), 32'b0001);
      step();
      #1;
      check("hold release 1", 32'(sched_w[0]), 32'b0010);
      step();
      #1;
      check("hold release 2", 32'(sched_w[0]), 32'b0001);
      step();

      // Two runners set the sticky error; reset mid-switch clears it.
      do_reset();
      set_thr(0, S_RUN, S_SRUN, S_IDLE, S_IDLE);
      drive();
      step();
      set_thr(0, S_RUN, S_IDLE, S_IDLE, S_IDLE);
      drive();
      #1;
      check("err sticky", 32'(err_w[0]), 32'd1);
      step();
      step();
      set_thr(0, S_RDY, S_RDY, S_IDLE, S_IDLE);
      drive();
      #1;
      check("pre-reset switch", 32'(sched_w[0] != 4'b0000), 32'd1);
      #1;
      do_reset();

      // Randomized traffic with the bench acting as the thread FSMs.
      for (int cyc = 0; cyc < 1500; cyc++) begin
         if (cyc % 250 == 249) do_reset();
         for (int d = 0; d < 3; d++) begin
            for (int t = 0; t < 4; t++) begin
               if ((st[d][t] == S_RUN || st[d][t] == S_SRUN) && $urandom_range(0, 99) < 6)
                  st[d][t] = S_WAIT;
               else if (st[d][t] == S_WAIT && $urandom_range(0, 99) < 20)
                  st[d][t] = S_RDY;
               else if ($urandom_range(0, 99) < 5)
                  st[d][t] = rand_code();
            end
         end
         fcl_hold = ($urandom_range(0, 99) < 15);
         drive();
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
